// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32 base opcodes, instruction field bit
// positions and the decode/read state encoding. Execute units import the
// same opcode constants so every stage agrees on the instruction classes.
package decode_pkg;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] MISC_MEM = 7'b0001111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;

    localparam int OPCODE_LSB = 0;
    localparam int OPCODE_MSB = 6;
    localparam int RD_LSB     = 7;
    localparam int RD_MSB     = 11;
    localparam int FUNCT3_LSB = 12;
    localparam int FUNCT3_MSB = 14;
    localparam int RS1_LSB    = 15;
    localparam int RS1_MSB    = 19;
    localparam int RS2_LSB    = 20;
    localparam int RS2_MSB    = 24;
    localparam int FUNCT7_LSB = 25;
    localparam int FUNCT7_MSB = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_t;

    // True for the opcodes this core implements.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        case (opc)
            OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR,
            LUI, AUIPC, MISC_MEM, SYSTEM: is_legal_opcode = 1'b1;
            default:                      is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_read.sv
// decode_read: front of the execute path. Accepts one fetched instruction,
// splits it into fields, reads both source registers from the synchronous
// register file and holds everything stable with read_valid high until the
// execute units report completion (exec_valid) or a flush arrives.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   fetch_valid/inst/pc/ready  fetch handshake (transfer on valid && ready)
//   rs1_addr, rs2_addr         register file read addresses
//   rs1_data, rs2_data         register file data, one cycle after address
//   decode_*                   latched instruction fields, word and PC
//   rs1_val, rs2_val           captured operands (x0 reads as 0)
//   read_valid                 fields and operands valid for execute
//   exec_valid                 execute units done, instruction retires
//   flush                      discard the current instruction
//   illegal_inst               (DECODE_ILLEGAL_CHECK_EN only) unknown opcode
//
// Optional feature: define DECODE_ILLEGAL_CHECK_EN to flag unknown opcodes.
// A flagged instruction parks in HOLD without read_valid until flush/reset.
module decode_read
    import decode_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_valid,
    input  logic [31:0]           fetch_inst,
    input  logic [XLEN-1:0]       fetch_pc,
    output logic                  fetch_ready,
    output logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_data,
    input  logic [XLEN-1:0]       rs2_data,
    output logic [6:0]            decode_opcode,
    output logic [2:0]            decode_funct3,
    output logic [6:0]            decode_funct7,
    output logic [REG_ADDR_W-1:0] decode_rd,
    output logic [31:0]           decode_inst,
    output logic [XLEN-1:0]       decode_pc,
    output logic [XLEN-1:0]       rs1_val,
    output logic [XLEN-1:0]       rs2_val,
    output logic                  read_valid,
`ifdef DECODE_ILLEGAL_CHECK_EN
    output logic                  illegal_inst,
`endif
    input  logic                  exec_valid,
    input  logic                  flush
);

    state_t                state, state_nxt;
    logic [31:0]           inst_p0;
    logic [XLEN-1:0]       pc_p0;
    logic [XLEN-1:0]       rs1_val_p1;
    logic [XLEN-1:0]       rs2_val_p1;
    logic                  accept;
    logic                  hold_lock;
    logic [REG_ADDR_W-1:0] rs1_idx;
    logic [REG_ADDR_W-1:0] rs2_idx;

    assign fetch_ready = (state == IDLE) && !reset;
    // A fetch presented together with flush is dropped.
    assign accept      = fetch_valid && fetch_ready && !flush;

    assign rs1_idx = inst_p0[RS1_MSB:RS1_LSB];
    assign rs2_idx = inst_p0[RS2_MSB:RS2_LSB];

    // In IDLE the RAM sees the incoming instruction so the data is ready
    // during READ; afterwards the latched copy keeps the address stable.
    always_comb begin
        rs1_addr = '0;
        rs2_addr = '0;
        if (!reset) begin
            if (state == IDLE) begin
                rs1_addr = fetch_inst[RS1_MSB:RS1_LSB];
                rs2_addr = fetch_inst[RS2_MSB:RS2_LSB];
            end else begin
                rs1_addr = rs1_idx;
                rs2_addr = rs2_idx;
            end
        end
    end

`ifdef DECODE_ILLEGAL_CHECK_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (state_nxt == IDLE) begin
            illegal_q <= 1'b0;
        end else if (state == READ) begin
            illegal_q <= !is_legal_opcode(inst_p0[OPCODE_MSB:OPCODE_LSB]) ||
                         (inst_p0[1:0] != 2'b11);
        end
    end

    assign hold_lock    = illegal_q;
    assign illegal_inst = illegal_q;
`else
    assign hold_lock = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = READ;
            READ:    state_nxt = HOLD;
            HOLD:    if (exec_valid && !hold_lock) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Stage p0: instruction and PC latched on acceptance
    always_ff @(posedge clk) begin
        if (reset) begin
            inst_p0 <= '0;
            pc_p0   <= '0;
        end else if (accept) begin
            inst_p0 <= fetch_inst;
            pc_p0   <= fetch_pc;
        end
    end

    // Stage p1: operands captured at the end of READ
    always_ff @(posedge clk) begin
        if (reset) begin
            rs1_val_p1 <= '0;
            rs2_val_p1 <= '0;
        end else if (state == READ) begin
            rs1_val_p1 <= (rs1_idx == '0) ? '0 : rs1_data;
            rs2_val_p1 <= (rs2_idx == '0) ? '0 : rs2_data;
        end
    end

    assign decode_opcode = inst_p0[OPCODE_MSB:OPCODE_LSB];
    assign decode_funct3 = inst_p0[FUNCT3_MSB:FUNCT3_LSB];
    assign decode_funct7 = inst_p0[FUNCT7_MSB:FUNCT7_LSB];
    assign decode_rd     = inst_p0[RD_MSB:RD_LSB];
    assign decode_inst   = inst_p0;
    assign decode_pc     = pc_p0;
    assign rs1_val       = rs1_val_p1;
    assign rs2_val       = rs2_val_p1;
    assign read_valid    = (state == HOLD) && !hold_lock && !reset;

endmodule

// File: doc/decode_read.md
Name: decode_read

Overview:
- Front of the execute path: accepts a fetched instruction, splits it into fields and reads both source registers from the synchronous register file.
- Holds the decoded instruction stable with read_valid asserted until the execute units report completion.
- Its decode_* and read_valid outputs drive every execute_* unit directly (fence, ALU, branch, load/store), so it is the stage feeding them.

Parameters:
- XLEN, 32, data/PC width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_valid  in  1  fetch presents an instruction.
- fetch_inst  in  32  instruction word.
- fetch_pc  in  XLEN  instruction address.
- fetch_ready  out  1  stage can accept; transfer when fetch_valid && fetch_ready.
- rs1_addr  out  REG_ADDR_W  register file read port A address.
- rs2_addr  out  REG_ADDR_W  register file read port B address.
- rs1_data  in  XLEN  port A data, valid one cycle after address.
- rs2_data  in  XLEN  port B data, valid one cycle after address.
- decode_opcode  out  7  inst[6:0].
- decode_funct3  out  3  inst[14:12].
- decode_funct7  out  7  inst[31:25].
- decode_rd  out  REG_ADDR_W  inst[11:7].
- decode_inst  out  32  full word, for immediate extraction by execute units.
- decode_pc  out  XLEN  latched PC.
- rs1_val  out  XLEN  captured rs1 value; x0 reads as 0.
- rs2_val  out  XLEN  captured rs2 value; x0 reads as 0.
- read_valid  out  1  decode fields and operands valid for execute.
- exec_valid  in  1  OR of all execute units' valid; instruction retires.
- flush  in  1  discard the current instruction (branch redirect).

Behaviour:
- State machine IDLE, READ, HOLD. Reset forces IDLE; all decode_*, rs*_val and rs*_addr clear to 0; read_valid=0; fetch_ready=0 during reset, then 1 in IDLE.
- fetch_ready = (state==IDLE). rs1_addr/rs2_addr are driven combinationally from fetch_inst[19:15]/[24:20] while in IDLE, and from the latched instruction otherwise, so the RAM address is stable for the read.
- IDLE: on a fetch handshake, latch inst and pc into the decode registers and go to READ.
- READ: one cycle; at its end capture rs1_data/rs2_data into rs1_val/rs2_val, forcing 0 when the index is 0; go to HOLD.
- HOLD: read_valid=1 and all outputs stable. When exec_valid=1, go to IDLE next cycle; read_valid drops the same edge.
- Latency: handshake edge to read_valid high = 2 cycles. Minimum issue interval = 3 cycles (IDLE, READ, HOLD). No back-to-back acceptance while busy.
- exec_valid is ignored outside HOLD.
- flush (any state) returns to IDLE next edge with read_valid=0. A fetch handshake in the same cycle as flush is dropped. flush has priority over exec_valid.
- Reset mid-operation: immediate return to IDLE; the instruction is lost and no read_valid pulse appears.
- Decode registers update only on acceptance; they hold their last value in IDLE, but read_valid=0 there.

Optional Feature:
- Macro DECODE_ILLEGAL_CHECK_EN.
- When defined:
  - Adds output illegal_inst (1 bit).
  - In READ, an opcode outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111, 1110011}, or inst[1:0]!=11, goes to HOLD with illegal_inst=1 and read_valid=0.
  - Leaves HOLD only on flush or reset; illegal_inst clears on exit.
- When undefined: no port; every opcode proceeds to read_valid.

Decomposition:
- Shared package decode_pkg:
  - opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, MISC_MEM=0001111, SYSTEM);
  - field bit-position constants;
  - state enum {IDLE, READ, HOLD}.
- Execute units import the same opcode constants.
- No sub-module needed; field extraction is inline.

Test Plan:
- Reset: hold reset 2 cycles -> read_valid=0, fetch_ready=0, all decode_* = 0; after release fetch_ready=1.
- Fence issue: fetch_inst=0x0FF0000F, rs1/rs2 RAM return 0 -> read_valid high 2 cycles after handshake; opcode=0001111, funct3=000; exec_valid pulse -> read_valid low next cycle, fetch_ready=1.
- Operands: inst 0x002081B3 (add x3,x1,x2), x1=5, x2=7 -> rs1_addr=1, rs2_addr=2, rs1_val=5, rs2_val=7, decode_rd=3; inst with rs1=0 and RAM returning 0xDEAD -> rs1_val=0.
- Stall: exec_valid held 0 for 10 cycles -> read_valid and all outputs constant; fetch_valid=1 meanwhile -> fetch_ready=0, no acceptance.
- Flush: assert flush during READ, and separately during HOLD -> read_valid never asserts (READ case) or drops next edge (HOLD case); flush together with exec_valid -> IDLE; same-cycle fetch dropped.
- With DECODE_ILLEGAL_CHECK_EN: fetch_inst=0x00000000 -> illegal_inst=1, read_valid=0, held until flush.
